// File: rtl/lvds_rx_pkg.sv
// Shared types and helpers for the LVDS frame receiver.
// Holds the FSM state encoding, tuser bit positions and the width helpers
// used to size the receiver's internal counters.
package lvds_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_t;

    // Sideband carried with each word when the tuser output is built in
    localparam int TUSER_W     = 2;
    localparam int TUSER_SHORT = 0;
    localparam int TUSER_OVF   = 1;

    // Output word width: one LANE_BITS slice per lane
    function automatic int data_width(input int lanes, input int lane_bits);
        return lanes * lane_bits;
    endfunction

    // Bits needed to hold any value in 0..max_val (at least one bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lvds_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for the receiver's output stream.
// pop_data always shows the head entry while the FIFO is non-empty and is
// forced to zero when empty so the stream data bus is clean after reset.
// A push while full is ignored; the caller is responsible for flagging it.
module lvds_rx_fifo
    import lvds_rx_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; no reset needed since empty gates the read port
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/lvds_rx_deser.sv
// Multi-lane LVDS frame receiver with AXI4-Stream output.
// Lanes are sampled while lvds_flag is high, deserialised LSB-first into
// DATA_W-bit words, held one slot in a staging register so the frame's
// last word can be tagged with tlast, then queued in an FWFT FIFO.
// Completed frames are counted and raise a level interrupt after
// IRQ_FRAMES frames or after IDLE_TIMEOUT idle cycles with frames pending.
// Optional build macro LVDS_RX_TUSER_EN adds m_axis_tuser[1:0]
// (bit0 = short frame, bit1 = overflow drop in frame, both on the tlast word).
// LANE_BITS must be at least 2 so a word never forms in the same cycle
// the staging register is flushing the previous frame's last word.
module lvds_rx_deser
    import lvds_rx_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int LANE_BITS    = 4,
    parameter int FRAME_WORDS  = 896,
    parameter int IRQ_FRAMES   = 1000,
    parameter int IDLE_TIMEOUT = 10000,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [LANES-1:0]             lvds_data,
    input  logic                         lvds_flag,
    input  logic                         fifo_rst_busy,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tvalid,
    output logic [LANES*LANE_BITS-1:0]   m_axis_tdata,
    output logic                         m_axis_tlast,
`ifdef LVDS_RX_TUSER_EN
    output logic [TUSER_W-1:0]           m_axis_tuser,
`endif
    output logic                         irq_req,
    input  logic                         irq_ack,
    output logic                         rx_busy,
    output logic [31:0]                  frame_total,
    output logic                         err_ovf,
    output logic                         err_short
);

    localparam int DATA_W = data_width(LANES, LANE_BITS);
    localparam int BIT_W  = cnt_width(LANE_BITS - 1);
    localparam int WORD_W = cnt_width(FRAME_WORDS);
    localparam int PEND_W = cnt_width(IRQ_FRAMES);
    localparam int IDLE_W = cnt_width(IDLE_TIMEOUT);
`ifdef LVDS_RX_TUSER_EN
    localparam int FIFO_W = DATA_W + 1 + TUSER_W;
`else
    localparam int FIFO_W = DATA_W + 1;
`endif

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(LANE_BITS - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(FRAME_WORDS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(IRQ_FRAMES);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);

    rx_state_t state;
    rx_state_t state_next;

    logic [LANES-1:0][LANE_BITS-1:0] shreg;
    logic [LANES-1:0][LANE_BITS-1:0] shreg_shift;
    logic [BIT_W-1:0]                bit_cnt;
    logic [WORD_W-1:0]               word_cnt;

    logic              sample_en;
    logic              word_form;
    logic              last_form;
    logic              frame_end_short;

    logic              stage_valid;
    logic              stage_final;
    logic [DATA_W-1:0] stage_data;

    logic              push;
    logic              push_last;
    logic              push_short;
    logic              frame_done;
    logic              drop;

    logic [FIFO_W-1:0] fifo_wdata;
    logic [FIFO_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    logic [PEND_W-1:0] pending;
    logic [IDLE_W-1:0] idle_cnt;
    logic              irq_set;

    // Lanes are only sampled while a frame is being accepted; the flag-rise
    // cycle in IDLE already carries the first bit of the frame.
    assign sample_en       = lvds_flag && !fifo_rst_busy && (state == IDLE || state == RECV);
    assign word_form       = sample_en && (bit_cnt == BIT_LAST);
    assign last_form       = word_form && (word_cnt == WORD_LAST);
    assign frame_end_short = (state == RECV) && (!lvds_flag || fifo_rst_busy);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: a full frame with the flag still high parks in DROP
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (lvds_flag) begin
                    state_next = fifo_rst_busy ? DROP : RECV;
                end
            end
            RECV: begin
                if (!lvds_flag || fifo_rst_busy) begin
                    state_next = IDLE;
                end else if (last_form) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (!lvds_flag) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // New lane bits enter at the MSB so the first-received bit ends at the LSB
    always_comb begin
        shreg_shift = '0;
        for (int i = 0; i < LANES; i++) begin
            shreg_shift[i] = {lvds_data[i], shreg[i][LANE_BITS-1:1]};
        end
    end

    // Per-lane shift registers advance only on sampled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (sample_en) begin
            shreg <= shreg_shift;
        end
    end

    // Bit and word position within the frame; cleared whenever not sampling,
    // which also throws away partial bits of a frame that ends early
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else if (!sample_en) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            if (word_form) begin
                word_cnt <= last_form ? '0 : word_cnt + 1'b1;
            end
        end
    end

    // Decide whether the staged word leaves this cycle and with which tlast
    always_comb begin
        push       = 1'b0;
        push_last  = 1'b0;
        push_short = 1'b0;
        if (stage_valid && stage_final) begin
            push      = 1'b1;
            push_last = 1'b1;
        end else if (stage_valid && word_form) begin
            push = 1'b1;
        end else if (stage_valid && frame_end_short) begin
            push       = 1'b1;
            push_last  = 1'b1;
            push_short = 1'b1;
        end
    end

    assign frame_done = push && push_last && !push_short;
    assign drop       = push && fifo_full;

    // Staging slot: a newly formed word replaces the one being pushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_final <= 1'b0;
            stage_data  <= '0;
        end else if (word_form) begin
            stage_valid <= 1'b1;
            stage_final <= last_form;
            stage_data  <= DATA_W'(shreg_shift);
        end else if (push) begin
            stage_valid <= 1'b0;
            stage_final <= 1'b0;
        end
    end

`ifdef LVDS_RX_TUSER_EN
    logic               frame_ovf;
    logic [TUSER_W-1:0] push_user;

    // Remembers any overflow drop since the current frame started
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ovf <= 1'b0;
        end else if (state == IDLE && sample_en) begin
            frame_ovf <= 1'b0;
        end else if (drop) begin
            frame_ovf <= 1'b1;
        end
    end

    // Sideband bits are only meaningful on the frame's tlast word
    always_comb begin
        push_user              = '0;
        push_user[TUSER_SHORT] = push_short;
        push_user[TUSER_OVF]   = push_last && frame_ovf;
    end

    assign fifo_wdata   = {push_user, push_last, stage_data};
    assign m_axis_tuser = fifo_rdata[DATA_W+1 +: TUSER_W];
`else
    assign fifo_wdata = {push_last, stage_data};
`endif

    assign fifo_pop = m_axis_tvalid && m_axis_tready;

    lvds_rx_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push && !fifo_full),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_rdata[DATA_W-1:0];
    assign m_axis_tlast  = fifo_rdata[DATA_W];
    assign rx_busy       = (state == RECV) || !fifo_empty;

    assign irq_set = (pending == PEND_MAX) || (idle_cnt == IDLE_MAX);

    // Lifetime frame counter, wraps at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_total <= '0;
        end else if (frame_done) begin
            frame_total <= frame_total + 32'd1;
        end
    end

    // Frames awaiting an interrupt and idle time since the last activity;
    // a frame finishing in the same cycle as an interrupt is not lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            idle_cnt <= '0;
        end else if (irq_set) begin
            pending  <= frame_done ? PEND_W'(1) : '0;
            idle_cnt <= '0;
        end else begin
            if (frame_done) begin
                pending <= pending + 1'b1;
            end
            if (state == RECV || pending == '0) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // Interrupt and sticky error flags; a new set beats a coincident ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_req   <= 1'b0;
            err_ovf   <= 1'b0;
            err_short <= 1'b0;
        end else begin
            if (irq_set) begin
                irq_req <= 1'b1;
            end else if (irq_ack) begin
                irq_req <= 1'b0;
            end
            if (drop) begin
                err_ovf <= 1'b1;
            end else if (irq_ack) begin
                err_ovf <= 1'b0;
            end
            if (frame_end_short) begin
                err_short <= 1'b1;
            end else if (irq_ack) begin
                err_short <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lvds_rx_deser.sv
// Directed testbench for lvds_rx_deser with small frame/IRQ parameters.
// Inputs change 1 time unit after each rising edge; outputs are read on
// the falling edge. Build with LVDS_RX_TUSER_EN to also check tuser.
module tb_lvds_rx_deser;

    localparam int LANES        = 2;
    localparam int LANE_BITS    = 4;
    localparam int FRAME_WORDS  = 4;
    localparam int IRQ_FRAMES   = 3;
    localparam int IDLE_TIMEOUT = 20;
    localparam int FIFO_DEPTH   = 4;
    localparam int DATA_W       = LANES * LANE_BITS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [LANES-1:0]  lvds_data = '0;
    logic              lvds_flag = 1'b0;
    logic              fifo_rst_busy = 1'b0;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tvalid;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic [1:0]        m_axis_tuser;
    logic              irq_req;
    logic              irq_ack = 1'b0;
    logic              rx_busy;
    logic [31:0]       frame_total;
    logic              err_ovf;
    logic              err_short;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] beat_data[$];
    logic              beat_last[$];
    logic [1:0]        beat_user[$];

    lvds_rx_deser #(
        .LANES        (LANES),
        .LANE_BITS    (LANE_BITS),
        .FRAME_WORDS  (FRAME_WORDS),
        .IRQ_FRAMES   (IRQ_FRAMES),
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lvds_data     (lvds_data),
        .lvds_flag     (lvds_flag),
        .fifo_rst_busy (fifo_rst_busy),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
`ifdef LVDS_RX_TUSER_EN
        .m_axis_tuser  (m_axis_tuser),
`endif
        .irq_req       (irq_req),
        .irq_ack       (irq_ack),
        .rx_busy       (rx_busy),
        .frame_total   (frame_total),
        .err_ovf       (err_ovf),
        .err_short     (err_short)
    );

`ifndef LVDS_RX_TUSER_EN
    assign m_axis_tuser = 2'b00;
`endif

    always #5 clk = ~clk;

    // Record every beat that will transfer at the next rising edge
    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            beat_data.push_back(m_axis_tdata);
            beat_last.push_back(m_axis_tlast);
            beat_user.push_back(m_axis_tuser);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beats();
        beat_data.delete();
        beat_last.delete();
        beat_user.delete();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        lvds_flag     = 1'b0;
        lvds_data     = '0;
        fifo_rst_busy = 1'b0;
        irq_ack       = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_beats();
    endtask

    // Word k of stimulus pattern 'mode'; mode 0 is the constant 0xC5 frame
    function automatic logic [7:0] word_val(input int mode, input int k);
        logic [7:0] m;
        logic [7:0] kk;
        if (mode == 0) return 8'hC5;
        m  = 8'(mode);
        kk = 8'(k);
        return (m << 4) ^ (kk * 8'h13) ^ 8'h5A;
    endfunction

    // Hold the flag high for n cycles sending pattern words LSB-first per lane,
    // then drop the flag for one cycle
    task automatic send_frame(input int n, input int mode);
        logic [7:0] w;
        for (int c = 0; c < n; c++) begin
            w            = word_val(mode, c / LANE_BITS);
            lvds_flag    = 1'b1;
            lvds_data[0] = w[c % LANE_BITS];
            lvds_data[1] = w[LANE_BITS + (c % LANE_BITS)];
            tick();
        end
        lvds_flag = 1'b0;
        lvds_data = '0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid: got %0b expected 0", m_axis_tvalid); end
        total++; if (m_axis_tdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_tdata: got %0h expected 0", m_axis_tdata); end
        total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("[TB] FAIL reset_tlast: got %0b expected 0", m_axis_tlast); end
        total++; if (irq_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %0b expected 0", irq_req); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b expected 0", rx_busy); end
        total++; if (frame_total !== 32'd0) begin bad++; $display("[TB] FAIL reset_frames: got %0d expected 0", frame_total); end
        total++; if ({err_ovf, err_short} !== 2'b00) begin bad++; $display("[TB] FAIL reset_err: got %0b expected 00", {err_ovf, err_short}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_frame();
        do_reset();
        send_frame(16, 0);
        repeat (4) tick();
        total++; if (beat_data.size() != 4) begin bad++; $display("[TB] FAIL full_beats: got %0d expected 4", beat_data.size()); end
        if (beat_data.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                total++; if (beat_data[k] !== 8'hC5) begin bad++; $display("[TB] FAIL full_data%0d: got %0h expected c5", k, beat_data[k]); end
                total++; if (beat_last[k] !== (k == 3)) begin bad++; $display("[TB] FAIL full_last%0d: got %0b expected %0b", k, beat_last[k], k == 3); end
            end
        end
        total++; if (frame_total !== 32'd1) begin bad++; $display("[TB] FAIL full_frames: got %0d expected 1", frame_total); end
        total++; if (err_short !== 1'b0) begin bad++; $display("[TB] FAIL full_short: got %0b expected 0", err_short); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL full_drained: got %0b expected 0", m_axis_tvalid); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("[TB] FAIL full_busy: got %0b expected 0", rx_busy); end
    endtask

    task automatic test_short_frame();
        clear_beats();
        send_frame(9, 1);
        repeat (4) tick();
        total++; if (beat_data.size() != 2) begin bad++; $display("[TB] FAIL short_beats: got %0d expected 2", beat_data.size()); end
        if (beat_data.size() == 2) begin
            for (int k = 0; k < 2; k++) begin
                total++; if (beat_data[k] !== word_val(1, k)) begin bad++; $display("[TB] FAIL short_data%0d: got %0h expected %0h", k, beat_data[k], word_val(1, k)); end
                total++; if (beat_last[k] !== (k == 1)) begin bad++; $display("[TB] FAIL short_last%0d: got %0b expected %0b", k, beat_last[k], k == 1); end
`ifdef LVDS_RX_TUSER_EN
                total++; if (beat_user[k] !== ((k == 1) ? 2'b01 : 2'b00)) begin bad++; $display("[TB] FAIL short_user%0d: got %0b expected %0b", k, beat_user[k], (k == 1) ? 2'b01 : 2'b00); end
`endif
            end
        end
        total++; if (err_short !== 1'b1) begin bad++; $display("[TB] FAIL short_flag: got %0b expected 1", err_short); end
        total++; if (frame_total !== 32'd1) begin bad++; $display("[TB] FAIL short_frames: got %0d expected 1", frame_total); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        total++; if (err_short !== 1'b0) begin bad++; $display("[TB] FAIL short_ack: got %0b expected 0", err_short); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] head;
        do_reset();
        m_axis_tready = 1'b0;
        send_frame(16, 2);
        send_frame(16, 3);
        repeat (2) tick();
        total++; if (err_ovf !== 1'b1) begin bad++; $display("[TB] FAIL bp_ovf: got %0b expected 1", err_ovf); end
        total++; if (beat_data.size() != 0) begin bad++; $display("[TB] FAIL bp_no_beats: got %0d expected 0", beat_data.size()); end
        total++; if (rx_busy !== 1'b1) begin bad++; $display("[TB] FAIL bp_busy: got %0b expected 1", rx_busy); end
        head = word_val(2, 0);
        for (int s = 0; s < 3; s++) begin
            total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== head) begin bad++; $display("[TB] FAIL bp_hold%0d: got v=%0b d=%0h expected v=1 d=%0h", s, m_axis_tvalid, m_axis_tdata, head); end
            tick();
        end
        m_axis_tready = 1'b1;
        repeat (6) tick();
        total++; if (beat_data.size() != 4) begin bad++; $display("[TB] FAIL bp_beats: got %0d expected 4", beat_data.size()); end
        if (beat_data.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                total++; if (beat_data[k] !== word_val(2, k)) begin bad++; $display("[TB] FAIL bp_data%0d: got %0h expected %0h", k, beat_data[k], word_val(2, k)); end
                total++; if (beat_last[k] !== (k == 3)) begin bad++; $display("[TB] FAIL bp_last%0d: got %0b expected %0b", k, beat_last[k], k == 3); end
            end
`ifdef LVDS_RX_TUSER_EN
            total++; if (beat_user[3] !== 2'b00) begin bad++; $display("[TB] FAIL bp_user: got %0b expected 00", beat_user[3]); end
`endif
        end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drained: got %0b expected 0", m_axis_tvalid); end
    endtask

    task automatic test_irq_frames();
        do_reset();
        repeat (3) send_frame(16, 0);
        total++; if (frame_total !== 32'd3) begin bad++; $display("[TB] FAIL irq_frames: got %0d expected 3", frame_total); end
        total++; if (irq_req !== 1'b0) begin bad++; $display("[TB] FAIL irq_early: got %0b expected 0", irq_req); end
        tick();
        total++; if (irq_req !== 1'b1) begin bad++; $display("[TB] FAIL irq_set: got %0b expected 1", irq_req); end
        repeat (3) send_frame(16, 0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        total++; if (irq_req !== 1'b1) begin bad++; $display("[TB] FAIL irq_set_wins: got %0b expected 1", irq_req); end
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        total++; if (irq_req !== 1'b0) begin bad++; $display("[TB] FAIL irq_ack: got %0b expected 0", irq_req); end
    endtask

    task automatic test_idle_timeout();
        do_reset();
        repeat (60) tick();
        total++; if (irq_req !== 1'b0) begin bad++; $display("[TB] FAIL idle_noframes: got %0b expected 0", irq_req); end
        send_frame(16, 0);
        repeat (20) tick();
        total++; if (irq_req !== 1'b0) begin bad++; $display("[TB] FAIL idle_early: got %0b expected 0", irq_req); end
        tick();
        total++; if (irq_req !== 1'b1) begin bad++; $display("[TB] FAIL idle_irq: got %0b expected 1", irq_req); end
    endtask

    task automatic test_fifo_busy();
        do_reset();
        fifo_rst_busy = 1'b1;
        send_frame(16, 0);
        fifo_rst_busy = 1'b0;
        repeat (3) tick();
        total++; if (beat_data.size() != 0) begin bad++; $display("[TB] FAIL busy_beats: got %0d expected 0", beat_data.size()); end
        total++; if (frame_total !== 32'd0) begin bad++; $display("[TB] FAIL busy_frames: got %0d expected 0", frame_total); end
        total++; if (err_short !== 1'b0) begin bad++; $display("[TB] FAIL busy_short: got %0b expected 0", err_short); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        do_reset();
        m_axis_tready = 1'b0;
        send_frame(16, 0);
        total++; if (frame_total !== 32'd1) begin bad++; $display("[TB] FAIL mid_before: got %0d expected 1", frame_total); end
        w = 8'h3A;
        for (int c = 0; c < 6; c++) begin
            lvds_flag    = 1'b1;
            lvds_data[0] = w[c % LANE_BITS];
            lvds_data[1] = w[LANE_BITS + (c % LANE_BITS)];
            tick();
        end
        rst_n = 1'b0;
        tick();
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL mid_tvalid: got %0b expected 0", m_axis_tvalid); end
        total++; if (frame_total !== 32'd0) begin bad++; $display("[TB] FAIL mid_frames: got %0d expected 0", frame_total); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy: got %0b expected 0", rx_busy); end
        lvds_flag = 1'b0;
        lvds_data = '0;
        rst_n     = 1'b1;
        m_axis_tready = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_backpressure();
        test_irq_frames();
        test_idle_timeout();
        test_fifo_busy();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
